// File: rtl/rf_pkg.sv
// Shared constants and the write-back request bundle used by the
// register-file write-back controller and its arbiter.
package rf_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The priority pointer only moves when both
// requesters collide, so a lone requester never steals the next tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    // ptr_q low favours requester 0 on the next tie, high favours requester 1
    always_comb begin
        gnt_o = req_i;
        ptr_d = ptr_q;
        if (req_i[0] && req_i[1]) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Write-back controller and busy-bit scoreboard in front of the 16x32 register
// file: merges ALU and load write-backs onto one write port and stalls issue.
module rf_wb_scoreboard
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic              iss_use1,
    input  logic [ADDR_W-1:0] iss_raddr1,
    input  logic              iss_use2,
    input  logic [ADDR_W-1:0] iss_raddr2,
    input  logic              iss_wen,
    input  logic [ADDR_W-1:0] iss_waddr,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_waddr,
    input  logic [DATA_W-1:0] alu_wdata,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [NREGS-1:0]  busy_vec,
    output logic              err_spurious
);

    wb_req_t             alu_req;
    wb_req_t             mem_req;
    wb_req_t             win_req;
    logic [1:0]          gnt;
    logic                iss_fire;

    logic [NREGS-1:0]    busy_q;
    logic [NREGS-1:0]    busy_d;
    logic                rf_wen_q;
    logic                rf_wen_d;
    logic [ADDR_W-1:0]   rf_waddr_q;
    logic [ADDR_W-1:0]   rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q;
    logic [DATA_W-1:0]   rf_wdata_d;
    logic                err_q;
    logic                err_d;

    always_comb begin
        alu_req = '{valid: alu_valid, waddr: alu_waddr, wdata: alu_wdata};
        mem_req = '{valid: mem_valid, waddr: mem_waddr, wdata: mem_wdata};
    end

    // Requester 0 is the ALU so it wins the first tie after reset
    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({mem_req.valid, alu_req.valid}),
        .gnt_o (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign win_req   = gnt[1] ? mem_req : alu_req;

    assign iss_ready = !((iss_use1 && busy_q[iss_raddr1]) ||
                         (iss_use2 && busy_q[iss_raddr2]) ||
                         (iss_wen  && busy_q[iss_waddr]));
    assign iss_fire  = iss_valid && iss_ready;

    // Clear is applied before set so a same-register collision leaves it busy
    always_comb begin
        busy_d = busy_q;
        if (rf_wen_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (iss_fire && iss_wen) begin
            busy_d[iss_waddr] = 1'b1;
        end
        err_d      = err_q | (rf_wen_q & ~busy_q[rf_waddr_q]);
        rf_wen_d   = |gnt;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (|gnt) begin
            rf_waddr_d = win_req.waddr;
            rf_wdata_d = win_req.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    assign busy_vec     = busy_q;
    assign rf_wen       = rf_wen_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed bench for rf_wb_scoreboard with a per-register reference model and
// a negedge compare process, plus hand-computed spot checks.
module tb_rf_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iss_valid = 1'b0;
    logic        iss_ready;
    logic        iss_use1 = 1'b0;
    logic [3:0]  iss_raddr1 = '0;
    logic        iss_use2 = 1'b0;
    logic [3:0]  iss_raddr2 = '0;
    logic        iss_wen = 1'b0;
    logic [3:0]  iss_waddr = '0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [3:0]  alu_waddr = '0;
    logic [31:0] alu_wdata = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [3:0]  mem_waddr = '0;
    logic [31:0] mem_wdata = '0;
    logic        rf_wen;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] busy_vec;
    logic        err_spurious;

    int checkCount = 0;
    int passCount  = 0;

    bit          modelBusy [16];
    bit          pendValid  = 1'b0;
    logic [3:0]  pendAddr   = '0;
    logic [31:0] pendData   = '0;
    bit          tiePrefMem = 1'b0;
    bit          errSticky  = 1'b0;

    rf_wb_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_use1     (iss_use1),
        .iss_raddr1   (iss_raddr1),
        .iss_use2     (iss_use2),
        .iss_raddr2   (iss_raddr2),
        .iss_wen      (iss_wen),
        .iss_waddr    (iss_waddr),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_waddr    (alu_waddr),
        .alu_wdata    (alu_wdata),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .busy_vec     (busy_vec),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    function automatic bit expReady();
        return !((iss_use1 && modelBusy[iss_raddr1]) ||
                 (iss_use2 && modelBusy[iss_raddr2]) ||
                 (iss_wen  && modelBusy[iss_waddr]));
    endfunction

    // Grant as {mem, alu}; on a collision whoever lost the previous tie wins
    function automatic bit [1:0] expGrant();
        if (alu_valid && mem_valid) begin
            return tiePrefMem ? 2'b10 : 2'b01;
        end
        return {mem_valid, alu_valid};
    endfunction

    function automatic logic [15:0] packBusy();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            v[i] = modelBusy[i];
        end
        return v;
    endfunction

    // Reference model: advances one clock edge at a time from the visible inputs
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int i = 0; i < 16; i++) begin
                    modelBusy[i] = 1'b0;
                end
                pendValid  = 1'b0;
                tiePrefMem = 1'b0;
                errSticky  = 1'b0;
            end else begin
                bit       rdy;
                bit [1:0] g;
                rdy = expReady();
                g   = expGrant();
                if (pendValid) begin
                    if (!modelBusy[pendAddr]) begin
                        errSticky = 1'b1;
                    end
                    modelBusy[pendAddr] = 1'b0;
                end
                if (iss_valid && rdy && iss_wen) begin
                    modelBusy[iss_waddr] = 1'b1;
                end
                pendValid = |g;
                if (g[0]) begin
                    pendAddr = alu_waddr;
                    pendData = alu_wdata;
                end else if (g[1]) begin
                    pendAddr = mem_waddr;
                    pendData = mem_wdata;
                end
                if (alu_valid && mem_valid) begin
                    tiePrefMem = !tiePrefMem;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                bit [1:0] g;
                g = expGrant();
                checkOutput("model iss_ready", 32'(iss_ready), 32'(expReady()));
                checkOutput("model alu_ready", 32'(alu_ready), 32'(g[0]));
                checkOutput("model mem_ready", 32'(mem_ready), 32'(g[1]));
                checkOutput("model busy_vec", 32'(busy_vec), 32'(packBusy()));
                checkOutput("model rf_wen", 32'(rf_wen), 32'(pendValid));
                checkOutput("model err_spurious", 32'(err_spurious), 32'(errSticky));
                if (pendValid) begin
                    checkOutput("model rf_waddr", 32'(rf_waddr), 32'(pendAddr));
                    checkOutput("model rf_wdata", rf_wdata, pendData);
                end
            end
        end
    end

    task automatic applyStimulus();
        @(posedge clk);
        #2;
        iss_valid = 1'b0; iss_use1 = 1'b0; iss_raddr1 = '0; iss_use2 = 1'b0; iss_raddr2 = '0;
        iss_wen = 1'b0; iss_waddr = '0;
        alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
        mem_valid = 1'b0; mem_waddr = '0; mem_wdata = '0;
    endtask

    task automatic setIssue(input bit u1, input logic [3:0] r1, input bit wen, input logic [3:0] wa);
        iss_valid = 1'b1; iss_use1 = u1; iss_raddr1 = r1; iss_wen = wen; iss_waddr = wa;
    endtask

    task automatic setAlu(input logic [3:0] a, input logic [31:0] d);
        alu_valid = 1'b1; alu_waddr = a; alu_wdata = d;
    endtask

    task automatic setMem(input logic [3:0] a, input logic [31:0] d);
        mem_valid = 1'b1; mem_waddr = a; mem_wdata = d;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Asynchronous reset with two busy registers and a write in flight
        applyStimulus(); setIssue(0, 0, 1, 4'd2);
        @(negedge clk);
        applyStimulus(); setIssue(0, 0, 1, 4'd5); setAlu(4'd10, 32'h55);
        @(negedge clk);
        checkOutput("t1 alu_ready", 32'(alu_ready), 32'd1);
        applyStimulus();
        #1;
        checkOutput("t1 busy before reset", 32'(busy_vec), 32'h0024);
        checkOutput("t1 rf_wen before reset", 32'(rf_wen), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("t1 busy in reset", 32'(busy_vec), 32'h0);
        checkOutput("t1 rf_wen in reset", 32'(rf_wen), 32'd0);
        checkOutput("t1 rf_waddr in reset", 32'(rf_waddr), 32'd0);
        checkOutput("t1 rf_wdata in reset", rf_wdata, 32'd0);
        checkOutput("t1 err in reset", 32'(err_spurious), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        // RAW on R5
        applyStimulus(); setIssue(0, 0, 1, 4'd5);
        @(negedge clk);
        checkOutput("t2 writer issues", 32'(iss_ready), 32'd1);
        applyStimulus(); setIssue(1, 4'd5, 0, 0); setAlu(4'd5, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("t2 RAW stall", 32'(iss_ready), 32'd0);
        checkOutput("t2 alu grant", 32'(alu_ready), 32'd1);
        checkOutput("t2 busy R5", 32'(busy_vec), 32'h0020);
        applyStimulus(); setIssue(1, 4'd5, 0, 0);
        @(negedge clk);
        checkOutput("t2 rf_wen", 32'(rf_wen), 32'd1);
        checkOutput("t2 rf_waddr", 32'(rf_waddr), 32'd5);
        checkOutput("t2 rf_wdata", rf_wdata, 32'hDEADBEEF);
        checkOutput("t2 still stalled", 32'(iss_ready), 32'd0);
        applyStimulus(); setIssue(1, 4'd5, 0, 0);
        @(negedge clk);
        checkOutput("t2 stall released", 32'(iss_ready), 32'd1);
        checkOutput("t2 busy cleared", 32'(busy_vec), 32'h0);

        // Tie arbitration
        for (int r = 1; r <= 4; r++) begin
            applyStimulus(); setIssue(0, 0, 1, 4'(r));
        end
        applyStimulus(); setAlu(4'd1, 32'h11); setMem(4'd2, 32'h22);
        @(negedge clk);
        checkOutput("t3 busy R1-R4", 32'(busy_vec), 32'h001E);
        checkOutput("t3 tie1 alu", 32'(alu_ready), 32'd1);
        checkOutput("t3 tie1 mem", 32'(mem_ready), 32'd0);
        applyStimulus(); setMem(4'd2, 32'h22);
        @(negedge clk);
        checkOutput("t3 mem after tie1", 32'(mem_ready), 32'd1);
        checkOutput("t3 first write", rf_wdata, 32'h11);
        applyStimulus(); setAlu(4'd3, 32'h33); setMem(4'd4, 32'h44);
        @(negedge clk);
        checkOutput("t3 tie2 mem", 32'(mem_ready), 32'd1);
        checkOutput("t3 tie2 alu", 32'(alu_ready), 32'd0);
        checkOutput("t3 second write", rf_wdata, 32'h22);
        applyStimulus(); setAlu(4'd3, 32'h33);
        @(negedge clk);
        checkOutput("t3 alu after tie2", 32'(alu_ready), 32'd1);
        checkOutput("t3 third write", rf_wdata, 32'h44);
        applyStimulus();
        @(negedge clk);
        checkOutput("t3 fourth write", rf_wdata, 32'h33);
        checkOutput("t3 fourth waddr", 32'(rf_waddr), 32'd3);
        applyStimulus();
        @(negedge clk);
        checkOutput("t3 busy drained", 32'(busy_vec), 32'h0);

        // WAW on R7
        applyStimulus(); setIssue(0, 0, 1, 4'd7);
        applyStimulus(); setIssue(0, 0, 1, 4'd7);
        @(negedge clk);
        checkOutput("t4 WAW stall", 32'(iss_ready), 32'd0);
        applyStimulus(); setIssue(0, 0, 1, 4'd7); setAlu(4'd7, 32'h77);
        @(negedge clk);
        checkOutput("t4 WAW stall at grant", 32'(iss_ready), 32'd0);
        applyStimulus(); setIssue(0, 0, 1, 4'd7);
        @(negedge clk);
        checkOutput("t4 rf_wen R7", 32'(rf_waddr), 32'd7);
        checkOutput("t4 WAW stall at write", 32'(iss_ready), 32'd0);
        applyStimulus(); setIssue(0, 0, 1, 4'd7);
        @(negedge clk);
        checkOutput("t4 WAW released", 32'(iss_ready), 32'd1);
        applyStimulus(); setAlu(4'd7, 32'h70);
        @(negedge clk);
        checkOutput("t4 R7 busy again", 32'(busy_vec), 32'h0080);
        repeat (2) applyStimulus();

        // Set R4 and clear R3 on the same edge
        applyStimulus(); setIssue(0, 0, 1, 4'd3);
        applyStimulus(); setAlu(4'd3, 32'h3);
        applyStimulus(); setIssue(0, 0, 1, 4'd4);
        @(negedge clk);
        checkOutput("t5 busy before", 32'(busy_vec), 32'h0008);
        checkOutput("t5 clearing R3", 32'(rf_waddr), 32'd3);
        applyStimulus();
        @(negedge clk);
        checkOutput("t5 busy after", 32'(busy_vec), 32'h0010);
        applyStimulus(); setAlu(4'd4, 32'h4);
        repeat (2) applyStimulus();
        @(negedge clk);
        checkOutput("t5 no error yet", 32'(err_spurious), 32'd0);

        // Spurious write-back to idle R9
        applyStimulus(); setMem(4'd9, 32'h99);
        @(negedge clk);
        checkOutput("t6 mem grant", 32'(mem_ready), 32'd1);
        applyStimulus();
        @(negedge clk);
        checkOutput("t6 rf_waddr R9", 32'(rf_waddr), 32'd9);
        checkOutput("t6 err not yet", 32'(err_spurious), 32'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            @(negedge clk);
            checkOutput("t6 err sticky", 32'(err_spurious), 32'd1);
        end
        applyStimulus();
        #1 rst = 1'b0;
        #1 checkOutput("t6 err cleared by reset", 32'(err_spurious), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) applyStimulus();
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rf_wb_scoreboard.md
Name: rf_wb_scoreboard

Overview:
Write-back controller and hazard scoreboard for the 16x32 register file (two asynchronous read ports, one synchronous write port).
- Arbitrates two write-back requesters, the ALU and the load/memory unit, onto the single write port using round-robin priority.
- Tracks one pending-write busy bit per register.
- Stalls instruction issue on RAW and WAW hazards.
- Sits between the issue stage, the execution units and the register file.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 4, register address width
- NREGS, 16, number of registers (must equal 2**ADDR_W)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- iss_valid  input  1  issue stage presents an instruction
- iss_ready  output  1  instruction may issue (no hazard)
- iss_use1  input  1  instruction reads source 1
- iss_raddr1  input  ADDR_W  source 1 register
- iss_use2  input  1  instruction reads source 2
- iss_raddr2  input  ADDR_W  source 2 register
- iss_wen  input  1  instruction writes a destination
- iss_waddr  input  ADDR_W  destination register
- alu_valid  input  1  ALU write-back request
- alu_ready  output  1  ALU request granted this cycle
- alu_waddr  input  ADDR_W  ALU destination
- alu_wdata  input  DATA_W  ALU result
- mem_valid  input  1  load write-back request
- mem_ready  output  1  load request granted this cycle
- mem_waddr  input  ADDR_W  load destination
- mem_wdata  input  DATA_W  load data
- rf_wen  output  1  register file write enable (registered)
- rf_waddr  output  ADDR_W  register file write address (registered)
- rf_wdata  output  DATA_W  register file write data (registered)
- busy_vec  output  NREGS  per-register pending-write bits
- err_spurious  output  1  sticky: write-back to a non-busy register

Behaviour:
- Reset (rst low, asynchronous) clears:
  - busy_vec to 0, rf_wen to 0, rf_waddr to 0, rf_wdata to 0, err_spurious to 0;
  - the round-robin pointer, so the ALU has priority.
  - Reset mid-operation drops in-flight scoreboard state and any registered write.
- iss_ready (combinational) is high unless any of the following holds:
  - iss_use1 and busy[iss_raddr1];
  - iss_use2 and busy[iss_raddr2];
  - iss_wen and busy[iss_waddr] (WAW stall).
  - iss_ready does not depend on iss_valid.
- Issue fire is iss_valid && iss_ready. If iss_wen is also high, busy[iss_waddr] is set at that posedge.
- Arbitration (combinational, one grant per cycle):
  - Only one requester valid: it is granted.
  - Both valid: the requester that did not win the last tie is granted, and the pointer flips only on a tie.
  - alu_ready / mem_ready equal their grant.
  - A requester holds valid, addr and data stable until its ready is high.
- Output stage: at the posedge after a grant, rf_wen<=1, rf_waddr<=the granted address and rf_wdata<=the granted data; otherwise rf_wen<=0.
  - The register file captures the write on the following posedge.
  - Total latency is 2 edges from grant to the register being updated.
- Busy clear: at the posedge where rf_wen is high, busy[rf_waddr] is cleared, the same edge the register file writes.
  - A reader sees iss_ready high in the cycle after that edge and reads the new value.
- Set and clear in the same cycle on different registers are both applied. Set and clear on the same register cannot occur because of the WAW stall; if it does, set wins.
- rf_wen high while busy[rf_waddr] is 0: err_spurious is set and stays set until reset. The write still proceeds.
- There is no hard-wired zero register; all NREGS registers are tracked.

Decomposition:
- Shared package rf_pkg holds:
  - DATA_W, ADDR_W and NREGS constants;
  - a wb_req_t struct {valid, waddr, wdata}.
- One sub-module, rr_arb2: a 2-requester round-robin arbiter with a tie-flip pointer, reusable for other shared ports.
- Scoreboard and output registers stay in the top module.

Test Plan:
1. Reset: drive rst low mid-run with busy_vec=16'h0024 and rf_wen=1 -> busy_vec=0, rf_wen=0 and err_spurious=0 immediately, before any clk edge.
2. RAW on R5:
   - issue with iss_wen=1, iss_waddr=5; next instruction has iss_use1=1, iss_raddr1=5 -> iss_ready=0;
   - alu_valid with waddr=5, data=32'hDEADBEEF is granted at cycle N -> rf_wen=1, waddr=5, wdata=DEADBEEF in cycle N+1;
   - iss_ready=1 in cycle N+2.
3. Tie arbitration:
   - ALU (R1, 32'h11) and MEM (R2, 32'h22) are valid together -> ALU is granted first, MEM the next cycle;
   - a second tie (R3/R4) -> MEM is granted first.
4. WAW: R7 busy and an instruction with iss_wen=1, iss_waddr=7, no sources -> iss_ready=0 until the cycle after the rf_wen for R7.
5. Independent set and clear: issue writing R4 in the same cycle that rf_wen clears R3 -> busy_vec goes from 16'h0008 to 16'h0010.
6. Spurious write: mem_valid with waddr=9 while busy[9]=0 -> rf_wen asserted for R9, and err_spurious=1 from the next cycle until reset.
